// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared state encoding and IEEE-754 field positions for the MAXNET controller
package maxnet_pkg;
  localparam int N_DEF = 4;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, CHECK, DONE} state_t;
endpackage

// File: rtl/maxnet_winner_det.sv
// maxnet_winner_det: flags which activations are strictly positive normals and whether exactly one survives
module maxnet_winner_det
  import maxnet_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*32-1:0] act,
  output logic [N-1:0]    nz,
  output logic            one_hot,
  output logic            none,
  output logic [IW-1:0]   idx
);
  // A zero exponent field covers +0, -0 and denormals alike
  always_comb begin
    nz = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      nz[i] = !act[32*i+SIGN_BIT] && |act[32*i+EXP_LO +: EXP_HI-EXP_LO+1];
      if (nz[i]) idx = IW'(i);
    end
  end
  assign none = nz == '0;
  assign one_hot = !none && (nz & (nz - N'(1))) == '0;
endmodule

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: sequences load/update/check rounds of a MAXNET datapath until one neuron survives
module maxnet_ctrl
  import maxnet_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int MAX_ITER = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*32-1:0] act,
  input  logic            dp_done,
  output logic            ld_in,
  output logic            dp_go,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [IW-1:0]   win_idx,
  output logic [5:0]      iter_cnt
);
  state_t state, nxt;
  logic [N-1:0] nz;
  logic one_hot, none, multi, lim;
  logic [IW-1:0] idx;
  maxnet_winner_det #(.N(N), .IW(IW)) u_det (
    .act(act),
    .nz(nz),
    .one_hot(one_hot),
    .none(none),
    .idx(idx)
  );
  assign multi = |nz && !one_hot;
  assign lim = iter_cnt >= 6'(MAX_ITER);
  always_comb begin
    nxt = state;
    ld_in = state == LOAD;
    dp_go = state == STEP;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = CHECK;
      STEP:    nxt = WAIT;
      WAIT:    nxt = dp_done ? CHECK : WAIT;
      CHECK:   nxt = multi && !lim ? STEP : DONE;
      DONE:    nxt = start ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Result registers move only when a check concludes the run
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      iter_cnt <= '0;
      err <= 1'b0;
      win_idx <= '0;
    end else begin
      state <= nxt;
      if (state == LOAD) begin
        iter_cnt <= '0;
        err <= 1'b0;
      end
      if (state == STEP) iter_cnt <= iter_cnt + 6'd1;
      if (state == CHECK && nxt == DONE) begin
        err <= none || multi;
        win_idx <= one_hot ? idx : '0;
      end
    end
endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb_maxnet_ctrl: directed checks of maxnet_ctrl against a behavioural MAXNET datapath model
module tb_maxnet_ctrl;
  localparam int N = 4;
  logic clk = 0, rst = 0, start = 0, dp_done;
  logic [N*32-1:0] act;
  logic ld_in, dp_go, busy, done, err;
  logic [1:0] win_idx;
  logic [5:0] iter_cnt;
  logic start1 = 0, dp_done1;
  logic [N*32-1:0] act1 = {4{32'h3F800000}};
  logic ld_in1, dp_go1, busy1, done1, err1;
  logic [1:0] win_idx1;
  logic [5:0] iter_cnt1;
  int errors = 0, checks = 0;
  real a[N], num[N];
  bit raw = 0;
  logic [N*32-1:0] raw_act = '0;
  int cnt, cnt1, go1;
  bit ok;
  int gos, lds;
  maxnet_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .act(act), .dp_done(dp_done),
    .ld_in(ld_in), .dp_go(dp_go), .busy(busy), .done(done), .err(err),
    .win_idx(win_idx), .iter_cnt(iter_cnt)
  );
  maxnet_ctrl #(.N(N), .MAX_ITER(5)) dut5 (
    .clk(clk), .rst(rst), .start(start1), .act(act1), .dp_done(dp_done1),
    .ld_in(ld_in1), .dp_go(dp_go1), .busy(busy1), .done(done1), .err(err1),
    .win_idx(win_idx1), .iter_cnt(iter_cnt1)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] to_f32(input real v);
    int e = 127;
    real m = v;
    if (v <= 0.0) return 32'h0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e < 1) return 32'h0;
    return {1'b0, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction
  function automatic real from_f32(input logic [31:0] b);
    real v = 1.0 + $itor({9'b0, b[22:0]}) / 8388608.0;
    int e = int'(b[30:23]) - 127;
    if (b[30:23] == 8'd0) return 0.0;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction
  function automatic real relu(input real x);
    return x > 0.0 ? x : 0.0;
  endfunction
  function automatic real sum_a();
    real s = 0.0;
    for (int i = 0; i < N; i++) s = s + a[i];
    return s;
  endfunction
  always_comb begin
    act = '0;
    for (int i = 0; i < N; i++) act[32*i +: 32] = raw ? raw_act[32*i +: 32] : to_f32(a[i]);
  end
  // Mock datapath: loads on ld_in, applies a_i + eps*sum(a_j, j!=i) with eps=-0.3, dp_done 4 cycles after dp_go
  initial for (int i = 0; i < N; i++) a[i] = 0.0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 0;
      dp_done <= 0;
    end else begin
      dp_done <= 0;
      if (ld_in) for (int i = 0; i < N; i++) a[i] <= num[i];
      if (dp_go) cnt <= 4;
      else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          dp_done <= 1;
          for (int i = 0; i < N; i++) a[i] <= relu(a[i] - 0.3 * (sum_a() - a[i]));
        end
      end
    end
  // Second mock never changes its activations
  always @(posedge clk or negedge rst)
    if (!rst) begin
      cnt1 <= 0;
      dp_done1 <= 0;
      go1 <= 0;
    end else begin
      dp_done1 <= 0;
      if (dp_go1) begin
        cnt1 <= 2;
        go1 <= go1 + 1;
      end else if (cnt1 != 0) begin
        cnt1 <= cnt1 - 1;
        if (cnt1 == 1) dp_done1 <= 1;
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_num(input real n0, input real n1, input real n2, input real n3);
    num[0] = n0;
    num[1] = n1;
    num[2] = n2;
    num[3] = n3;
  endtask
  task automatic run(output int g, output int l, output bit fin);
    g = 0;
    l = 0;
    fin = 0;
    start = 1;
    for (int k = 0; k < 400 && !fin; k++) begin
      tick();
      g += int'(dp_go);
      l += int'(ld_in);
      if (done) fin = 1;
    end
  endtask
  initial begin
    set_num(0.0, 0.0, 0.0, 0.0);
    #3;
    tick();
    chk("reset_outs", longint'({ld_in, dp_go, busy, done, err, win_idx, iter_cnt}), 0);
    rst = 1;
    tick();
    set_num(0.0, 0.0, 1.0, 0.0);
    start = 1;
    tick();
    tick();
    chk("lat2_done", longint'(done), 0);
    chk("lat2_ld", longint'(ld_in), 0);
    tick();
    chk("lat3_done", longint'(done), 1);
    chk("uniq_win", longint'(win_idx), 2);
    chk("uniq_err", longint'(err), 0);
    chk("uniq_iter", longint'(iter_cnt), 0);
    start = 0;
    tick();
    chk("uniq_idle", longint'(done), 0);
    set_num(0.0, 0.0, 0.0, 0.0);
    run(gos, lds, ok);
    chk("zero_fin", longint'(ok), 1);
    chk("zero_err", longint'(err), 1);
    chk("zero_iter", longint'(iter_cnt), 0);
    chk("zero_win", longint'(win_idx), 0);
    start = 0;
    tick();
    raw = 1;
    raw_act = {32'hBF800000, 32'h40000000, 32'h00000001, 32'h80000000};
    run(gos, lds, ok);
    chk("raw_fin", longint'(ok), 1);
    chk("raw_err", longint'(err), 0);
    chk("raw_win", longint'(win_idx), 2);
    chk("raw_gos", longint'(gos), 0);
    start = 0;
    tick();
    raw = 0;
    set_num(from_f32(32'h3ECCCCCD), from_f32(32'h3FCCCCCD), from_f32(32'h3FD9999A), from_f32(32'h3FA66666));
    run(gos, lds, ok);
    chk("comp_fin", longint'(ok), 1);
    chk("comp_err", longint'(err), 0);
    chk("comp_win", longint'(win_idx), 2);
    chk("comp_iter", longint'(iter_cnt), 5);
    chk("comp_gos", longint'(gos), 5);
    lds = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      lds += int'(ld_in);
    end
    chk("hold_done", longint'(done), 1);
    chk("hold_no_reload", longint'(lds), 0);
    start = 0;
    tick();
    chk("release_done", longint'({done, busy}), 0);
    start = 1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      if (dp_go) ok = 1;
    end
    chk("rst_reach_step", longint'(ok), 1);
    tick();
    chk("rst_in_wait", longint'({busy, dp_go, ld_in, done}), 4'b1000);
    #2 rst = 0;
    #1;
    chk("rst_async_outs", longint'({ld_in, dp_go, busy, done, err, win_idx, iter_cnt}), 0);
    start = 0;
    tick();
    rst = 1;
    tick();
    chk("rst_idle", longint'({busy, done}), 0);
    run(gos, lds, ok);
    chk("rerun_fin", longint'(ok), 1);
    chk("rerun_ld", longint'(lds), 1);
    chk("rerun_err", longint'(err), 0);
    chk("rerun_win", longint'(win_idx), 2);
    chk("rerun_iter", longint'(iter_cnt), 5);
    start = 0;
    tick();
    start1 = 1;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick();
      if (done1) ok = 1;
    end
    chk("lim_fin", longint'(ok), 1);
    chk("lim_gos", longint'(go1), 5);
    chk("lim_err", longint'(err1), 1);
    chk("lim_iter", longint'(iter_cnt1), 5);
    chk("lim_win", longint'(win_idx1), 0);
    start1 = 0;
    tick();
    chk("lim_idle", longint'(done1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 Parameter N, default 4: number of competing neurons.
REQ-002 Parameter MAX_ITER, default 32: iteration limit before error; range 1..63.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low (0 = reset).
REQ-005 Port start, input, 1: level request to run one competition.
REQ-006 Port act, input, N*32: current IEEE-754 single activations from datapath; neuron i in bits [32i+31:32i].
REQ-007 Port dp_done, input, 1: one-cycle pulse from datapath; update step complete, act valid next cycle.
REQ-008 Port ld_in, output, 1: one-cycle strobe; datapath loads num1..numN into activation registers.
REQ-009 Port dp_go, output, 1: one-cycle strobe; datapath starts one update step (ReLU(a_i + eps*sum a_j, j!=i)).
REQ-010 Port busy, output, 1: high in every state except IDLE and DONE.
REQ-011 Port done, output, 1: high while in DONE.
REQ-012 Port err, output, 1: valid while done=1; 1 = no unique winner.
REQ-013 Port win_idx, output, clog2(N): index of surviving neuron; valid while done=1 and err=0.
REQ-014 Port iter_cnt, output, 6: number of dp_go strobes issued in the current run.

Function
REQ-015 FSM states IDLE, LOAD, STEP, WAIT, CHECK, DONE; binary encoded.
REQ-016 IDLE: start=1 -> LOAD; otherwise stay.
REQ-017 LOAD: ld_in=1 for exactly one cycle, iter_cnt cleared to 0, err cleared -> CHECK.
REQ-018 CHECK: compute nz[i] = (sign=0) and (exponent field != 0); denormals and -0 count as zero.
REQ-019 CHECK: popcount(nz)=1 -> DONE, err=0, win_idx = index of the set bit.
REQ-020 CHECK: popcount(nz)=0 -> DONE, err=1, win_idx=0.
REQ-021 CHECK: popcount(nz)>1 and iter_cnt=MAX_ITER -> DONE, err=1, win_idx=0.
REQ-022 CHECK: popcount(nz)>1 and iter_cnt<MAX_ITER -> STEP.
REQ-023 STEP: dp_go=1 for exactly one cycle, iter_cnt increments by 1 -> WAIT.
REQ-024 WAIT: stay until dp_done=1, then -> CHECK on the next cycle.
REQ-025 dp_done outside WAIT is ignored.
REQ-026 DONE: hold done, err, win_idx stable; start=0 -> IDLE; start=1 -> stay (no auto-restart).
REQ-027 start changes while busy=1 are ignored; a run is never aborted except by rst.
REQ-028 Latency: start=1 in IDLE to done=1 = 3 cycles when the inputs already have a unique winner.
REQ-029 Latency per iteration = 3 cycles + datapath latency (STEP, WAIT..dp_done, CHECK).
REQ-030 win_idx and err are registered; they change only on the CHECK->DONE transition.

Reset
REQ-031 rst=0 forces state IDLE, iter_cnt=0, win_idx=0, err=0, done=0, busy=0, ld_in=0, dp_go=0, asynchronously.
REQ-032 rst asserted mid-run abandons the run; after release the block waits in IDLE for start.

Structure
REQ-033 Shared package maxnet_pkg holds the state enumeration, N default, FP field constants (sign bit 31, exponent [30:23]).
REQ-034 One sub-module maxnet_winner_det: combinational, act -> nz vector, one_hot flag, none flag, binary index.
REQ-035 The controller contains no floating-point arithmetic; all FP math stays in the datapath.

Verification
REQ-036 act={0.4,1.6,1.7,1.3} (0x3ECCCCCD,0x3FCCCCCD,0x3FD9999A,0x3FA66666), mock datapath applies eps=-0.3 with 4-cycle dp_done -> done=1, err=0, win_idx=2, iter_cnt>=1.
REQ-037 act={0,0,0x3F800000,0} at start -> done 3 cycles after start, iter_cnt=0, win_idx=2, dp_go never asserted.
REQ-038 act all 0x00000000 -> done=1, err=1, iter_cnt=0.
REQ-039 Mock datapath that never reduces act={1.0,1.0,1.0,1.0}, MAX_ITER=5 -> exactly 5 dp_go pulses, then done=1, err=1.
REQ-040 rst=0 while in WAIT -> all outputs 0 immediately; after release and start=1, ld_in pulses again and the run completes normally.
REQ-041 start held high through DONE -> done stays 1, no second ld_in; start=0 -> IDLE next cycle, done=0.
